// File: rtl/fifo_pkg.sv
// Shared sizing and types for the single-clock FIFO.
package fifo_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr,
  output data_t rdata
);

  data_t mem [DEPTH];

  // Storage is deliberately not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// 8 x 32 first-word-fall-through FIFO: pointer control, full/empty and handshakes
// around a register-array storage block.
module sync_fifo
  import fifo_pkg::*;
(
  input  logic  io_clk,
  input  logic  io_rst,
  input  logic  io_write_valid,
  output logic  io_write_ready,
  input  data_t io_write_bits,
  output logic  io_read_valid,
  input  logic  io_read_ready,
  output data_t io_read_bits
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic empty;
  logic full;
  logic write_fire;
  logic read_fire;

  // Handshake: a transfer happens on a rising edge exactly when valid and ready
  // are both high in that cycle. ready/valid here depend only on the registered
  // pointers, so a same-cycle transfer on the opposite side never unblocks this one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign io_write_ready = !full;
  assign io_read_valid  = !empty;

  assign write_fire = io_write_valid && io_write_ready && !io_rst;
  assign read_fire  = io_read_valid && io_read_ready && !io_rst;

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_fire) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (read_fire) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  sync_fifo_mem u_mem (
    .clk   (io_clk),
    .we    (write_fire),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (io_write_bits),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (io_read_bits)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed table plus hand-written sequences for the sync_fifo, checked against
// hand-computed values and a queue model of the FIFO contents.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic  io_clk = 1'b0;
  logic  io_rst;
  logic  io_write_valid;
  logic  io_write_ready;
  data_t io_write_bits;
  logic  io_read_valid;
  logic  io_read_ready;
  data_t io_read_bits;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic  wv;
    data_t wd;
    logic  rr;
    logic  exp_wready;
    logic  exp_rvalid;
    data_t exp_rbits;
    logic  chk_bits;
  } vec_t;

  vec_t vecs[$];

  sync_fifo dut (
    .io_clk         (io_clk),
    .io_rst         (io_rst),
    .io_write_valid (io_write_valid),
    .io_write_ready (io_write_ready),
    .io_write_bits  (io_write_bits),
    .io_read_valid  (io_read_valid),
    .io_read_ready  (io_read_ready),
    .io_read_bits   (io_read_bits)
  );

  // clock
  always #5 io_clk = ~io_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wv, input data_t wd, input logic rr,
                              input logic ew, input logic ev, input data_t eb, input logic cb);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.exp_wready = ew; v.exp_rvalid = ev; v.exp_rbits = eb; v.chk_bits = cb;
    return v;
  endfunction

  task automatic drive(input logic wv, input data_t wd, input logic rr);
    io_write_valid = wv;
    io_write_bits  = wd;
    io_read_ready  = rr;
  endtask

  // One cycle against the queue model: check current outputs, drive, clock, update model.
  task automatic model_cycle(input string tag, input logic wv, input data_t wd, input logic rr);
    bit wf;
    bit rf;
    check({tag, "_wready"}, 32'(io_write_ready), 32'(exp_q.size() < DEPTH));
    check({tag, "_rvalid"}, 32'(io_read_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check({tag, "_rbits"}, io_read_bits, exp_q[0]);
    wf = wv && (exp_q.size() < DEPTH);
    rf = rr && (exp_q.size() > 0);
    drive(wv, wd, rr);
    @(posedge io_clk); #1;
    if (rf) void'(exp_q.pop_front());
    if (wf) exp_q.push_back(wd);
  endtask

  initial begin
    logic [31:0] base;
    base = 32'h1111_1111;

    // reset held for 3 cycles
    io_rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (3) @(posedge io_clk);
    #1;
    check("rst_wready", 32'(io_write_ready), 32'd1);
    check("rst_rvalid", 32'(io_read_valid), 32'd0);
    check("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    check("rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
    io_rst = 1'b0;

    // fill: head stays 0x11111111, full after the 8th write
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b1, data_t'(base * 32'(k)), 1'b0, k < 8, 1'b1, base, 1'b1));
    // 9th word refused
    vecs.push_back(mk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, base, 1'b1));
    // drain 8 in order
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b0, '0, 1'b1, 1'b1, k < 8, data_t'(base * 32'(k + 1)), k < 8));
    // empty: read refused, write lands and becomes head next cycle
    vecs.push_back(mk(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1));
    vecs.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].rr);
      @(posedge io_clk); #1;
      check($sformatf("vec%0d_wready", i), 32'(io_write_ready), 32'(vecs[i].exp_wready));
      check($sformatf("vec%0d_rvalid", i), 32'(io_read_valid), 32'(vecs[i].exp_rvalid));
      if (vecs[i].chk_bits)
        check($sformatf("vec%0d_rbits", i), io_read_bits, vecs[i].exp_rbits);
    end

    // wrap: push 5, pop 3, push 6 crosses slot 7 -> 0 and ends full
    for (int k = 0; k < 5; k++) model_cycle("wrap_push", 1'b1, 32'hC000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 3; k++) model_cycle("wrap_pop", 1'b0, '0, 1'b1);
    for (int k = 5; k < 11; k++) model_cycle("wrap_push2", 1'b1, 32'hC000_0000 + 32'(k), 1'b0);
    check("wrap_full_wready", 32'(io_write_ready), 32'd0);
    // full + simultaneous read: write still refused
    model_cycle("full_rw", 1'b1, 32'hBAD0_0000, 1'b1);
    for (int k = 0; k < 8; k++) model_cycle("wrap_drain", 1'b0, '0, 1'b1);
    check("wrap_empty_rvalid", 32'(io_read_valid), 32'd0);

    // mid-occupancy simultaneous push/pop, then randomised phases
    for (int k = 0; k < 3; k++) model_cycle("mid_push", 1'b1, 32'hE000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 4; k++) model_cycle("mid_rw", 1'b1, 32'hE100_0000 + 32'(k), 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 32; k++) model_cycle("rnd_w", 1'($urandom_range(0, 1)), $urandom, 1'b0);
      for (int k = 0; k < 32; k++) model_cycle("rnd_r", 1'b0, '0, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 32; k++)
      model_cycle("rnd_rw", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // mid-reset with 4 words stored; bounded drain first
    for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) model_cycle("pre_drain", 1'b0, '0, 1'b1);
    check("pre_drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) model_cycle("mr_push", 1'b1, 32'hF000_0000 + 32'(k), 1'b0);
    io_rst = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b1);
    @(posedge io_clk); #1;
    check("mr_rvalid", 32'(io_read_valid), 32'd0);
    check("mr_wready", 32'(io_write_ready), 32'd1);
    @(posedge io_clk); #1;
    check("mr_hold_rvalid", 32'(io_read_valid), 32'd0);
    io_rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    model_cycle("post_rst", 1'b1, 32'h5555_AAAA, 1'b0);
    model_cycle("post_rst2", 1'b0, '0, 1'b1);
    model_cycle("post_rst3", 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
